// File: rtl/eight_queen_controller.sv
// Sequencing FSM for the 8-queen solver datapath. Runs a column-wise depth-first
// backtracking search (one queen per column, rows scanned 0..7), then streams the
// eight board rows. Outputs are decoded from the registered state; only the CHECK
// and ADVANCE strobes also depend on the datapath status inputs.
module eight_queen_controller #(
  parameter int unsigned BT_W = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            safe_or_not,
  input  logic            row_carry,
  input  logic            clm_carry,
  input  logic            ccarry,
  input  logic [2:0]      clm_counter,
  output logic            dp_clear,
  output logic            row_rst,
  output logic            rld_en,
  output logic            rcount_en,
  output logic            up_count_en,
  output logic            down_count_en,
  output logic            update,
  output logic            fill_erase,
  output logic            sld_en,
  output logic            serase,
  output logic            mld_en,
  output logic            ccounter_rst,
  output logic            ccounter_en,
  output logic            busy,
  output logic            out_valid,
  output logic            done,
  output logic            no_solution,
  output logic [BT_W-1:0] backtrack_cnt
);

  typedef enum logic [3:0] {
    StIdle, StInit, StCheck, StPlace, StNextCol, StPop,
    StReload, StErase, StAdvance, StOutInit, StOutput, StDone
  } state_e;

  state_e          state_q, state_d;
  logic            no_solution_q, no_solution_d;
  logic [BT_W-1:0] bt_q, bt_d;
  logic            clm_zero;

  // Popping with the column counter at 0 would empty an already empty stack,
  // so column 0 exhaustion ends the search instead.
  assign clm_zero      = (clm_counter == 3'd0);
  assign no_solution   = no_solution_q;
  assign backtrack_cnt = bt_q;

  // State, sticky no-solution flag and backtrack counter; synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= StIdle;
      no_solution_q <= 1'b0;
      bt_q          <= '0;
    end else begin
      state_q       <= state_d;
      no_solution_q <= no_solution_d;
      bt_q          <= bt_d;
    end
  end

  // Next-state decode and datapath strobes.
  always_comb begin
    state_d       = state_q;
    no_solution_d = no_solution_q;
    bt_d          = bt_q;
    dp_clear      = 1'b0;
    row_rst       = 1'b0;
    rld_en        = 1'b0;
    rcount_en     = 1'b0;
    up_count_en   = 1'b0;
    down_count_en = 1'b0;
    update        = 1'b0;
    fill_erase    = 1'b0;
    sld_en        = 1'b0;
    serase        = 1'b0;
    mld_en        = 1'b0;
    ccounter_rst  = 1'b0;
    ccounter_en   = 1'b0;
    busy          = 1'b1;
    out_valid     = 1'b0;
    done          = 1'b0;
    unique case (state_q)
      StIdle, StDone: begin
        busy = 1'b0;
        done = (state_q == StDone);
        if (start) begin
          state_d       = StInit;
          no_solution_d = 1'b0;
          bt_d          = '0;
        end
      end
      StInit: begin
        dp_clear     = 1'b1;
        row_rst      = 1'b1;
        ccounter_rst = 1'b1;
        state_d      = StCheck;
      end
      StCheck: begin
        if (safe_or_not) begin
          state_d = StPlace;
        end else if (!row_carry) begin
          rcount_en = 1'b1;
        end else if (clm_zero) begin
          state_d       = StDone;
          no_solution_d = 1'b1;
        end else begin
          state_d = StPop;
        end
      end
      StPlace: begin
        update     = 1'b1;
        fill_erase = 1'b1;
        sld_en     = 1'b1;
        state_d    = clm_carry ? StOutInit : StNextCol;
      end
      StNextCol: begin
        up_count_en = 1'b1;
        row_rst     = 1'b1;
        state_d     = StCheck;
      end
      StPop: begin
        // ML captures the stack top on the same edge the entry is discarded.
        mld_en        = 1'b1;
        serase        = 1'b1;
        down_count_en = 1'b1;
        if (bt_q != '1) bt_d = bt_q + BT_W'(1);
        state_d = StReload;
      end
      StReload: begin
        rld_en  = 1'b1;
        state_d = StErase;
      end
      StErase: begin
        update  = 1'b1;
        state_d = StAdvance;
      end
      StAdvance: begin
        if (!row_carry) begin
          rcount_en = 1'b1;
          state_d   = StCheck;
        end else if (clm_zero) begin
          state_d       = StDone;
          no_solution_d = 1'b1;
        end else begin
          state_d = StPop;
        end
      end
      StOutInit: begin
        ccounter_rst = 1'b1;
        state_d      = StOutput;
      end
      StOutput: begin
        out_valid   = 1'b1;
        ccounter_en = 1'b1;
        if (ccarry) state_d = StDone;
      end
      default: begin
        busy    = 1'b0;
        state_d = StIdle;
      end
    endcase
  end

endmodule

// File: tb/tb_eight_queen_controller.sv
// Bench for eight_queen_controller: a behavioural datapath (counters, board, stack,
// ML register) closes the loop around the controller; the cell-safety input comes
// either from real queen attacks on the board or from a per-cell mask. Expected
// results come from constant tables and a plain-arithmetic DFS solver.
module tb_eight_queen_controller;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, start;
  logic        safe_or_not, row_carry, clm_carry, ccarry;
  logic [2:0]  clm_counter;
  logic        dp_clear, row_rst, rld_en, rcount_en, up_count_en, down_count_en;
  logic        update, fill_erase, sld_en, serase, mld_en, ccounter_rst, ccounter_en;
  logic        busy, out_valid, done, no_solution;
  logic [15:0] backtrack_cnt;

  logic        dp_clear_s, row_rst_s, rld_en_s, rcount_en_s, up_count_en_s, down_count_en_s;
  logic        update_s, fill_erase_s, sld_en_s, serase_s, mld_en_s, ccounter_rst_s;
  logic        ccounter_en_s, busy_s, out_valid_s, done_s, no_solution_s;
  logic [1:0]  backtrack_cnt_s;

  eight_queen_controller #(.BT_W(16)) dut (
    .clk(clk), .rst(rst), .start(start), .safe_or_not(safe_or_not),
    .row_carry(row_carry), .clm_carry(clm_carry), .ccarry(ccarry),
    .clm_counter(clm_counter), .dp_clear(dp_clear), .row_rst(row_rst), .rld_en(rld_en),
    .rcount_en(rcount_en), .up_count_en(up_count_en), .down_count_en(down_count_en),
    .update(update), .fill_erase(fill_erase), .sld_en(sld_en), .serase(serase),
    .mld_en(mld_en), .ccounter_rst(ccounter_rst), .ccounter_en(ccounter_en),
    .busy(busy), .out_valid(out_valid), .done(done), .no_solution(no_solution),
    .backtrack_cnt(backtrack_cnt)
  );

  // Narrow-counter copy driven by the same status inputs, for saturation.
  eight_queen_controller #(.BT_W(2)) dut_s (
    .clk(clk), .rst(rst), .start(start), .safe_or_not(safe_or_not),
    .row_carry(row_carry), .clm_carry(clm_carry), .ccarry(ccarry),
    .clm_counter(clm_counter), .dp_clear(dp_clear_s), .row_rst(row_rst_s),
    .rld_en(rld_en_s), .rcount_en(rcount_en_s), .up_count_en(up_count_en_s),
    .down_count_en(down_count_en_s), .update(update_s), .fill_erase(fill_erase_s),
    .sld_en(sld_en_s), .serase(serase_s), .mld_en(mld_en_s),
    .ccounter_rst(ccounter_rst_s), .ccounter_en(ccounter_en_s), .busy(busy_s),
    .out_valid(out_valid_s), .done(done_s), .no_solution(no_solution_s),
    .backtrack_cnt(backtrack_cnt_s)
  );

  localparam logic [15:0] C_DP = 16'h8000, C_RR = 16'h4000, C_RLD = 16'h2000;
  localparam logic [15:0] C_RC = 16'h1000, C_UP = 16'h0800, C_DN = 16'h0400;
  localparam logic [15:0] C_UPD = 16'h0200, C_FE = 16'h0100, C_SLD = 16'h0080;
  localparam logic [15:0] C_SER = 16'h0040, C_MLD = 16'h0020, C_CCR = 16'h0010;
  localparam logic [15:0] C_CCE = 16'h0008, C_BSY = 16'h0004, C_OV = 16'h0002;
  localparam logic [15:0] C_DN1 = 16'h0001;

  logic [15:0] ctrl, ctrl_s;
  assign ctrl = {dp_clear, row_rst, rld_en, rcount_en, up_count_en, down_count_en, update,
                 fill_erase, sld_en, serase, mld_en, ccounter_rst, ccounter_en, busy,
                 out_valid, done};
  assign ctrl_s = {dp_clear_s, row_rst_s, rld_en_s, rcount_en_s, up_count_en_s,
                   down_count_en_s, update_s, fill_erase_s, sld_en_s, serase_s, mld_en_s,
                   ccounter_rst_s, ccounter_en_s, busy_s, out_valid_s, done_s};

  // ---------------- behavioural datapath ----------------
  logic [2:0]  m_row, m_clm, m_cc;
  logic [63:0] m_board;            // bit clm*8+row
  logic [5:0]  m_stack [8];        // {row, col}
  int          m_sp;
  logic [5:0]  m_ml;
  int          src_mode;           // 0: real queen attacks, 1: mask
  logic [63:0] src_mask;           // bit clm*8+row = cell safe

  function automatic logic real_safe(input logic [63:0] b, input logic [2:0] r3,
                                     input logic [2:0] c3);
    int r, c, dr, dc;
    r = int'(r3);
    c = int'(c3);
    for (int cc = 0; cc < 8; cc++)
      for (int rr = 0; rr < 8; rr++) begin
        dr = rr - r;
        dc = cc - c;
        if (b[cc*8+rr] && !(dr == 0 && dc == 0) &&
            (dr == 0 || dc == 0 || dr == dc || dr == -dc)) return 1'b0;
      end
    return 1'b1;
  endfunction

  function automatic logic [7:0] board_row(input logic [63:0] b, input logic [2:0] rr);
    logic [7:0] v;
    for (int c = 0; c < 8; c++) v[c] = b[c*8 + int'(rr)];
    return v;
  endfunction

  always_comb begin
    safe_or_not = (src_mode == 0) ? real_safe(m_board, m_row, m_clm) : src_mask[{m_clm, m_row}];
    row_carry   = (m_row == 3'd7);
    clm_carry   = (m_clm == 3'd7);
    ccarry      = (m_cc == 3'd7);
    clm_counter = m_clm;
  end

  always @(posedge clk) begin
    if (rst || dp_clear) begin
      m_board <= '0;
      m_sp    <= 0;
      m_ml    <= '0;
      m_clm   <= '0;
    end else begin
      if (up_count_en) m_clm <= m_clm + 3'd1;
      if (down_count_en) m_clm <= m_clm - 3'd1;
      if (update) m_board[{m_clm, m_row}] <= fill_erase;
      if (sld_en && m_sp < 8) m_stack[m_sp] <= {m_row, m_clm};
      if (mld_en && m_sp > 0) m_ml <= m_stack[m_sp-1];
      m_sp <= m_sp + (sld_en ? 1 : 0) - (serase ? 1 : 0);
    end
    if (rst || row_rst) m_row <= '0;
    else if (rld_en) m_row <= m_ml[5:3];
    else if (rcount_en) m_row <= m_row + 3'd1;
    if (rst || ccounter_rst) m_cc <= '0;
    else if (ccounter_en) m_cc <= m_cc + 3'd1;
  end

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Per-cycle rules: strobe exclusion, stack bounds, reload column, copies agree.
  always @(negedge clk) begin
    n_checks++;
    if ($countones({row_rst, rld_en, rcount_en}) > 1 || (up_count_en && down_count_en) ||
        (sld_en && serase) || (sld_en && m_sp >= 8) || (serase && m_sp <= 0) ||
        (busy && done) || (rld_en && m_ml[2:0] != m_clm) || ctrl !== ctrl_s) begin
      n_fail++;
      $display("FAIL cycle_rules @%0t: ctrl %h ctrl_s %h sp %0d", $time, ctrl, ctrl_s, m_sp);
    end
  end

  // ---------------- reference solver ----------------
  function automatic bit ref_ok(input int mode, input logic [63:0] mask, input int sol[8],
                                input int c, input int r);
    if (mode != 0) return mask[c*8+r];
    for (int j = 0; j < c; j++)
      if (sol[j] == r || sol[j] - r == c - j || r - sol[j] == c - j) return 1'b0;
    return 1'b1;
  endfunction

  task automatic ref_solve(input int mode, input logic [63:0] mask, output bit nosol,
                           output int pops, output logic [63:0] rows);
    int sol[8];
    int c, r;
    bit fin;
    for (int k = 0; k < 8; k++) sol[k] = 0;
    c = 0; r = 0; pops = 0; nosol = 1'b0; fin = 1'b0; rows = '0;
    while (!fin) begin
      while (r < 8 && !ref_ok(mode, mask, sol, c, r)) r++;
      if (r < 8) begin
        sol[c] = r;
        if (c == 7) fin = 1'b1;
        else begin c++; r = 0; end
      end else if (c == 0) begin
        nosol = 1'b1; fin = 1'b1;
      end else begin
        pops++; c--; r = sol[c] + 1;
      end
    end
    if (!nosol) for (int k = 0; k < 8; k++) rows[sol[k]*8 + k] = 1'b1;
  endtask

  // ---------------- drivers ----------------
  task automatic run_solve(input int mode, input logic [63:0] mask, output bit to,
                           output int nvalid, output logic [63:0] rows);
    int cyc;
    rows = '0; nvalid = 0; cyc = 0;
    @(negedge clk);
    src_mode = mode; src_mask = mask; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("init_dp_clear", dp_clear, 1);
    check("init_nosol_cleared", no_solution, 0);
    check("init_bt_cleared", backtrack_cnt, 0);
    while (!done && cyc < 20000) begin
      @(negedge clk);
      cyc++;
      if (out_valid) begin
        if (nvalid < 8) rows[nvalid*8 +: 8] = board_row(m_board, m_cc);
        nvalid++;
      end
    end
    to = !done;
  endtask

  task automatic solve_and_check(input string name, input int mode, input logic [63:0] mask,
                                 input bit exp_nosol, input int exp_bt,
                                 input logic [63:0] exp_rows);
    bit to;
    int nv;
    logic [63:0] rows;
    run_solve(mode, mask, to, nv, rows);
    check({name, "_timeout"}, to, 0);
    if (to) begin
      rst = 1'b1; @(negedge clk); rst = 1'b0;
    end else begin
      check({name, "_done"}, done, 1);
      check({name, "_nosol"}, no_solution, exp_nosol);
      check({name, "_bt"}, backtrack_cnt, exp_bt);
      check({name, "_bt_sat2"}, backtrack_cnt_s, (exp_bt > 3) ? 3 : exp_bt);
      check({name, "_nvalid"}, nv, exp_nosol ? 0 : 8);
      if (!exp_nosol) check({name, "_rows"}, rows, exp_rows);
    end
  endtask

  typedef struct {
    string       name;
    int          mode;
    logic [63:0] mask;
    bit          nosol;
    int          bt;        // -1: take from reference solver
    logic [63:0] rows;      // byte k = board row k
  } vec_t;

  vec_t        vecs[5];
  logic [15:0] trace_exp[18];

  initial begin
    bit          m_nosol, to;
    int          m_pops, cyc, nv;
    logic [63:0] m_rows, mask;

    vecs[0] = '{"real8", 0, 64'h0, 1'b0, -1, 64'h0420080280104001};
    vecs[1] = '{"never_safe", 1, 64'h0, 1'b1, 0, 64'h0};
    vecs[2] = '{"col0_only", 1, 64'hFF, 1'b1, 8, 64'h0};
    vecs[3] = '{"diag", 1, 64'h8040201008040201, 1'b0, 0, 64'h8040201008040201};
    vecs[4] = '{"row0", 1, 64'h0101010101010101, 1'b0, 0, 64'hFF};

    trace_exp = '{C_DP|C_RR|C_CCR|C_BSY, C_BSY, C_UPD|C_FE|C_SLD|C_BSY, C_UP|C_RR|C_BSY,
                  C_RC|C_BSY, C_RC|C_BSY, C_RC|C_BSY, C_RC|C_BSY, C_RC|C_BSY, C_RC|C_BSY,
                  C_RC|C_BSY, C_BSY, C_MLD|C_SER|C_DN|C_BSY, C_RLD|C_BSY, C_UPD|C_BSY,
                  C_RC|C_BSY, C_BSY, C_UPD|C_FE|C_SLD|C_BSY};

    rst = 1'b1; start = 1'b0; src_mode = 0; src_mask = '0;
    repeat (3) @(negedge clk);
    check("reset_ctrl", ctrl, 0);
    check("reset_bt", backtrack_cnt, 0);
    check("reset_nosol", no_solution, 0);
    rst = 1'b0;
    @(negedge clk);
    check("idle_ctrl", ctrl, 0);

    // Column-0-only mask: exact strobe order, start while busy ignored.
    src_mode = 1; src_mask = 64'hFF; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 18; i++) begin
      if (i > 0) @(negedge clk);
      check($sformatf("trace_%0d", i), ctrl, trace_exp[i]);
      if (i == 13) check("trace_bt_after_pop", backtrack_cnt, 1);
      if (i == 5) start = 1'b1;
      if (i == 6) start = 1'b0;
    end
    cyc = 0;
    while (!done && cyc < 5000) begin @(negedge clk); cyc++; end
    check("trace_timeout", done, 1);
    check("trace_nosol", no_solution, 1);
    check("trace_bt", backtrack_cnt, 8);
    check("trace_bt_sat2", backtrack_cnt_s, 3);
    @(negedge clk);
    check("done_holds", ctrl, C_DN1);

    // Directed table.
    for (int v = 0; v < 5; v++) begin
      ref_solve(vecs[v].mode, vecs[v].mask, m_nosol, m_pops, m_rows);
      solve_and_check(vecs[v].name, vecs[v].mode, vecs[v].mask, vecs[v].nosol,
                      (vecs[v].bt < 0) ? m_pops : vecs[v].bt, vecs[v].rows);
    end

    // Reset during OUTPUT aborts to IDLE, then a clean restart.
    @(negedge clk);
    src_mode = 0; start = 1'b1;
    @(negedge clk);
    start = 1'b0; cyc = 0; nv = 0;
    while (nv < 3 && cyc < 20000) begin
      @(negedge clk); cyc++;
      if (out_valid) nv++;
    end
    check("rst_reached_output", nv, 3);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rst_abort_ctrl", ctrl, 0);
    check("rst_abort_bt", backtrack_cnt, 0);
    @(negedge clk);
    check("rst_idle_ctrl", ctrl, 0);
    ref_solve(0, '0, m_nosol, m_pops, m_rows);
    solve_and_check("restart", 0, '0, 1'b0, m_pops, 64'h0420080280104001);

    // Random safety masks against the reference solver; columns 3..7 never empty
    // so any exhaustive search stays short.
    for (int t = 0; t < 15; t++) begin
      mask = '0;
      for (int b = 0; b < 64; b++) if ($urandom_range(0, 3) == 0) mask[b] = 1'b1;
      for (int c = 3; c < 8; c++)
        if (mask[c*8 +: 8] == 8'h0) mask[c*8 + int'($urandom_range(0, 7))] = 1'b1;
      ref_solve(1, mask, m_nosol, m_pops, m_rows);
      solve_and_check($sformatf("rand%0d", t), 1, mask, m_nosol, m_pops, m_rows);
    end

    to = 1'b0;
    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
